// File: rtl/incdec_unit.sv
// incdec_unit: registered unsigned inc/dec/step unit with wrap or saturate,
// result flags, sticky overflow, result chaining and valid/ready on both sides.
module incdec_unit #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  inp,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        op,
    input  logic              sat,
    input  logic              use_prev,
    input  logic              clr_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out,
    output logic              zero,
    output logic              carry,
    output logic              sat_hit,
    output logic              ovf_sticky
);
    typedef enum logic {EMPTY, FULL} state_e;
    state_e           state_q;
    logic [WIDTH-1:0] out_q, prev_q, a, out_d;
    logic [WIDTH:0]   d, raw;
    logic             zero_q, carry_q, sat_hit_q, sticky_q, carry_d, sat_hit_d, accept;
    assign in_ready  = rst & ((state_q == EMPTY) | out_ready);
    assign accept    = in_valid & in_ready;
    assign a         = use_prev ? prev_q : inp;
    assign d         = op[1] ? (WIDTH+1)'(step) : (WIDTH+1)'(1);
    // One spare bit holds the carry on add and the borrow on subtract.
    assign raw       = op[0] ? {1'b0, a} - d : {1'b0, a} + d;
    assign carry_d   = raw[WIDTH];
    assign sat_hit_d = sat & carry_d;
    assign out_d     = sat_hit_d ? {WIDTH{~op[0]}} : raw[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            prev_q    <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            sat_hit_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            if (accept) begin
                state_q   <= FULL;
                out_q     <= out_d;
                prev_q    <= out_d;
                zero_q    <= (out_d == '0);
                carry_q   <= carry_d;
                sat_hit_q <= sat_hit_d;
            end else if (out_ready) begin
                state_q <= EMPTY;
            end
            sticky_q <= (accept & carry_d) | (sticky_q & ~clr_sticky);
        end
    end
    assign out_valid  = (state_q == FULL);
    assign out        = out_q;
    assign zero       = zero_q;
    assign carry      = carry_q;
    assign sat_hit    = sat_hit_q;
    assign ovf_sticky = sticky_q;
endmodule
